// File: rtl/function_scanner_if.sv
// Bus between a truth-table scanner and the bench or BIST logic around it.
// The master side starts scans and returns the block output; the slave side is the scanner.
interface function_scanner_if;
    logic        start;
    logic        y_in;
    logic        a;
    logic        b;
    logic        c;
    logic        d;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] table_out;
    logic [4:0]  fail_count;
    logic [3:0]  first_fail;

    modport master (
        output start, y_in,
        input  a, b, c, d, busy, done, pass, table_out, fail_count, first_fail
    );

    modport slave (
        input  start, y_in,
        output a, b, c, d, busy, done, pass, table_out, fail_count, first_fail
    );
endinterface

// File: rtl/function_scanner.sv
// Exhaustive truth-table scanner for a 4-input function block: walks {a,b,c,d} through 0..15,
// captures y for each vector and grades the captured table against EXPECTED.
module function_scanner #(
    parameter logic [15:0] EXPECTED = 16'h34CD,
    parameter int unsigned SETTLE   = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    function_scanner_if.slave   bus
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] HOLD   = 2'd1;
    localparam logic [1:0] SAMPLE = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    // A vector window is SETTLE cycles of HOLD followed by one SAMPLE cycle, so with SETTLE=0
    // each vector goes straight to SAMPLE.
    localparam logic [1:0] enter_state = (SETTLE == 0) ? SAMPLE : HOLD;
    localparam logic [3:0] hold_init   = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);

    logic [1:0]  state;
    logic [3:0]  idx;
    logic [3:0]  cnt;
    logic [15:0] table_r;
    logic [4:0]  fail_r;
    logic [3:0]  first_r;
    logic        pass_r;

    logic        y_sample;
    logic        mismatch;
    logic [4:0]  fail_next;

    // X or Z from the block under scan is recorded as 0
    assign y_sample  = (bus.y_in === 1'b1);
    assign mismatch  = (y_sample != EXPECTED[idx]);
    assign fail_next = fail_r + 5'(mismatch);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= 4'd0;
            cnt     <= 4'd0;
            table_r <= 16'd0;
            fail_r  <= 5'd0;
            first_r <= 4'd0;
            pass_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        idx     <= 4'd0;
                        cnt     <= hold_init;
                        table_r <= 16'd0;
                        fail_r  <= 5'd0;
                        first_r <= 4'd0;
                        pass_r  <= 1'b0;
                        state   <= enter_state;
                    end
                end
                HOLD: begin
                    if (cnt == 4'd0) begin
                        state <= SAMPLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                SAMPLE: begin
                    table_r[idx] <= y_sample;
                    if (mismatch) begin
                        fail_r <= fail_next;
                        if (fail_r == 5'd0) begin
                            first_r <= idx;
                        end
                    end
                    // pass must reflect this last sample, so it is graded from fail_next
                    if (idx == 4'd15) begin
                        pass_r <= (fail_next == 5'd0);
                        state  <= DONE;
                    end else begin
                        idx   <= idx + 4'd1;
                        cnt   <= hold_init;
                        state <= enter_state;
                    end
                end
                DONE: begin
                    idx   <= 4'd0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = (state == HOLD) || (state == SAMPLE);
    assign bus.done       = (state == DONE);
    assign {bus.a, bus.b, bus.c, bus.d} = bus.busy ? idx : 4'd0;
    assign bus.pass       = pass_r;
    assign bus.table_out  = table_r;
    assign bus.fail_count = fail_r;
    assign bus.first_fail = first_r;

endmodule
